// File: rtl/bellman_pkg.sv
// bellman_pkg: shared types and constants for the Bellman-Ford scheduler slice
package bellman_pkg;

    localparam int EDGE_IDX_W    = 5;
    localparam int EDGE_WEIGHT_W = 32;

    // Matches the engine's "unreachable" initial distance.
    localparam logic [EDGE_WEIGHT_W-1:0] INF_WEIGHT = 32'h777f_ffff;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_KICK,
        S_RUN
    } sched_state_t;

    typedef struct packed {
        logic [EDGE_IDX_W-1:0]           row;
        logic [EDGE_IDX_W-1:0]           col;
        logic signed [EDGE_WEIGHT_W-1:0] weight;
    } edge_upd_t;

endpackage

// File: rtl/bellman_sched_fifo.sv
// upd_fifo: single-clock FIFO holding edge-weight updates until the engine is idle
module upd_fifo
    import bellman_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  edge_upd_t din,
    input  logic      pop,
    output edge_upd_t dout,
    output logic      full,
    output logic      empty,
    output logic      last
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    edge_upd_t     mem_q [DEPTH];
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign last    = cnt_q == CW'(1);
    assign dout    = mem_q[rp_q];

    // Pointer and occupancy tracking; simultaneous push and pop both take effect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + AW'(do_push);
            rp_q  <= rp_q + AW'(do_pop);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din;
    end

endmodule

// File: rtl/bellman_sched.sv
// bellman_sched: sequences the Bellman-Ford engine, buffers feed updates, arbitrates vertex-matrix port A
module bellman_sched
    import bellman_pkg::*;
#(
    parameter int IDX_W      = EDGE_IDX_W,
    parameter int WEIGHT_W   = EDGE_WEIGHT_W,
    parameter int VERT_W     = 38,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [IDX_W-1:0]    src,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [IDX_W-1:0]    upd_row,
    input  logic [IDX_W-1:0]    upd_col,
    input  logic [WEIGHT_W-1:0] upd_weight,
    output logic                adjmat_we,
    output logic [IDX_W-1:0]    adjmat_wr_row,
    output logic [IDX_W-1:0]    adjmat_wr_col,
    output logic [WEIGHT_W-1:0] adjmat_wr_data,
    output logic                bellman_reset,
    output logic [IDX_W-1:0]    bellman_src,
    input  logic                bellman_done,
    output logic                vm_sel,
    output logic [IDX_W-1:0]    vm_addr,
    input  logic [VERT_W-1:0]   vm_q,
    input  logic                rd_req,
    input  logic [IDX_W-1:0]    rd_addr,
    output logic                rd_valid,
    output logic [VERT_W-1:0]   rd_data
);

    sched_state_t     state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0] src_q, src_d;
    logic             tmo_q, tmo_d;
    logic             done_q, done_d;
    logic             rdv_q, rdv_d;
    logic             pop, sel;
    logic             full, empty, last, push;
    edge_upd_t        head;

    assign upd_ready = reset_n && !full;
    assign push      = upd_valid && upd_ready;

    upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .din    ('{row: upd_row, col: upd_col, weight: upd_weight}),
        .pop    (adjmat_we),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .last   (last)
    );

    // Next-state, engine control and port A arbitration.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        rdv_d   = 1'b0;
        pop     = 1'b0;
        sel     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src;
                    tmo_d   = 1'b0;
                    state_d = empty ? S_KICK : S_DRAIN;
                end else begin
                    pop   = !empty;
                    sel   = rd_req;
                    rdv_d = rd_req;
                end
            end
            S_DRAIN: begin
                pop     = !empty;
                state_d = (empty || (last && !push)) ? S_KICK : S_DRAIN;
            end
            S_KICK: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (bellman_done) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers; reset abandons any solve without a done pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            tmo_q   <= 1'b0;
            done_q  <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            rdv_q   <= rdv_d;
        end
    end

    assign busy           = reset_n && state_q != S_IDLE;
    assign done           = done_q;
    assign timeout_err    = tmo_q;
    assign bellman_reset  = !reset_n || state_q != S_RUN;
    assign bellman_src    = src_q;
    assign adjmat_we      = reset_n && pop;
    assign adjmat_wr_row  = head.row;
    assign adjmat_wr_col  = head.col;
    assign adjmat_wr_data = head.weight;
    assign vm_sel         = reset_n && sel;
    assign vm_addr        = vm_sel ? rd_addr : '0;
    assign rd_valid       = rdv_q;
    assign rd_data        = rdv_q ? vm_q : '0;

endmodule

// File: doc/bellman_sched.md
Name: bellman_sched

Overview:
Sequencer and resource arbiter wrapped around the Bellman-Ford relaxation engine in the arbitrage datapath.
- Accepts a host "solve from src" command and parks, kicks and monitors the engine through its active-high reset and done signals.
- Buffers market-feed edge-weight updates in a FIFO so the adjacency matrix never changes mid-solve, and drains them while the engine is idle.
- Multiplexes the vertex-matrix read port A between the engine and host readout of distance/predecessor results.

Parameters:
IDX_W, 5, vertex index width (NODES <= 2^IDX_W)
WEIGHT_W, 32, signed edge weight width
VERT_W, 38, vertex-matrix word width ({flag, pred, weight})
FIFO_DEPTH, 16, update FIFO entries (power of two)
TIMEOUT, 65535, maximum RUN cycles before abort

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
start  in  1  solve request, sampled in IDLE only
src  in  IDX_W  source vertex for the solve
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a solve completes
timeout_err  out  1  sticky abort flag
upd_valid  in  1  feed update valid
upd_ready  out  1  FIFO not full
upd_row  in  IDX_W  edge source vertex
upd_col  in  IDX_W  edge destination vertex
upd_weight  in  WEIGHT_W  new edge weight
adjmat_we  out  1  adjacency-matrix write enable
adjmat_wr_row  out  IDX_W  write row
adjmat_wr_col  out  IDX_W  write column
adjmat_wr_data  out  WEIGHT_W  write data
bellman_reset  out  1  engine reset, active high
bellman_src  out  IDX_W  latched source vertex to engine
bellman_done  in  1  engine done (sticky until engine reset)
vm_sel  out  1  vertex-matrix port A owner: 0 = engine, 1 = scheduler
vm_addr  out  IDX_W  scheduler address for port A
vm_q  in  VERT_W  port A read data
rd_req  in  1  host read request
rd_addr  in  IDX_W  host read vertex
rd_valid  out  1  host read data valid
rd_data  out  VERT_W  host read data

Behaviour:
- Reset (reset_n low at a clk edge):
  - State IDLE; FIFO emptied.
  - bellman_reset=1; busy, done, timeout_err, adjmat_we, rd_valid, vm_sel = 0; bellman_src=0; upd_ready=0 while reset_n is low.
  - Reset mid-RUN or mid-DRAIN aborts: pending updates are lost and no done pulse is issued.
- States: IDLE, DRAIN, KICK, RUN.
- bellman_reset=0 only in RUN; the engine is parked in every other state.
- IDLE:
  - start=1 latches src into bellman_src and clears timeout_err.
  - Next state is DRAIN if the FIFO is non-empty, else KICK.
- DRAIN:
  - One FIFO pop per cycle, presented as adjmat_we=1 with row/col/data from the head entry.
  - Moves to KICK in the cycle after the last pop.
- KICK: exactly one cycle; guarantees at least one reset cycle with bellman_src stable.
- RUN:
  - A 16-bit cycle counter starts at 0.
  - bellman_done=1 -> IDLE with done=1 for exactly one cycle.
  - Counter reaching TIMEOUT-1 without done -> IDLE with timeout_err=1 and no done pulse.
- FIFO push: when upd_valid & upd_ready, in any state.
  - upd_ready = !full.
  - A push and a pop in the same cycle are both honoured.
  - Entries are written in arrival order; no coalescing.
- FIFO pop:
  - Happens in IDLE (background drain, one per cycle) and in DRAIN.
  - Never happens in KICK or RUN; adjmat_we=0 there.
- Host read:
  - Honoured only in IDLE when start=0. start has priority over rd_req.
  - Issue cycle t: vm_sel=1 and vm_addr=rd_addr.
  - Cycle t+1: rd_valid=1 and rd_data=vm_q, regardless of state.
  - rd_req outside IDLE is dropped: no rd_valid, and vm_sel stays 0.
- start while busy is ignored.
- A done pulse in cycle t makes the scheduler IDLE in cycle t, so start may be accepted in that same cycle.

Decomposition:
- Shared package bellman_pkg holds:
  - sched_state_t enum.
  - edge_upd_t struct {row, col, weight}.
  - INF_WEIGHT constant (0x777fffff, matching the engine's setup value).
- Natural sub-module: upd_fifo, a synchronous single-clock FIFO of edge_upd_t with full/empty and DEPTH parameter.
- Port A mux and state machine live in bellman_sched.

Test Plan:
- Reset with upd_valid=1, start=1 held -> outputs at reset values, FIFO empty, bellman_reset=1, no adjmat_we.
- start, src=3, FIFO empty at edge t -> KICK in t+1, bellman_reset=0 from t+2, bellman_src=3; bellman_done at t+102 -> done high one cycle, busy low, bellman_reset=1.
- 3 updates pushed during RUN -> adjmat_we stays 0; after done, 3 consecutive writes in push order (e.g. (1,2,-5), (2,0,7), (0,1,3)).
- FIFO_DEPTH=4, 5 pushes during RUN -> upd_ready low after the 4th and the 5th held off; then start with 4 pending -> 4 DRAIN cycles of writes, then KICK.
- TIMEOUT=50, bellman_done never asserted -> IDLE after 50 RUN cycles, timeout_err=1, no done; next start clears timeout_err.
- IDLE rd_req addr=5 with vm_q=0x2_0000_0010 -> vm_sel=1 for one cycle, rd_valid next cycle with that data; rd_req during RUN -> no rd_valid; rd_req together with start -> start accepted, no rd_valid.
